// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for register bank write arbitration.
// Default widths, write-request bundle and CE decode.
package reg_bank_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int ADDR_SPAN = 1 << DEF_ADDR_WIDTH;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } reg_wr_t;

  function automatic logic [ADDR_SPAN-1:0] onehot_decode(
    input logic [DEF_ADDR_WIDTH-1:0] addr
  );
    logic [ADDR_SPAN-1:0] oh;
    oh = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Requester-side write bus: packed per-master valid/addr/data
// plus one-hot ready returned by the arbiter.
interface reg_bank_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;

  modport master (
    output REQ_VALID,
    output REQ_ADDR,
    output REQ_DATA,
    input  REQ_READY
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_ADDR,
    input  REQ_DATA,
    output REQ_READY
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Pointer moves past the granted index on each UPDATE strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               ENABLE,
  input  logic               UPDATE,
  input  logic [NUM_REQ-1:0] VALID,
  output logic [NUM_REQ-1:0] GRANT,
  output logic [IW-1:0]      GRANT_IDX
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  int            idx;

  // first valid requester at or above the pointer, wrapping
  always_comb begin
    GRANT     = '0;
    GRANT_IDX = '0;
    found     = 1'b0;
    idx       = 0;
    if (ENABLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!found && VALID[idx]) begin
          found      = 1'b1;
          GRANT[idx] = 1'b1;
          GRANT_IDX  = IW'(idx);
        end
      end
    end
  end

  // pointer steps to the requester after the winner
  always_comb begin
    ptr_d = ptr_q;
    if (UPDATE) begin
      if (GRANT_IDX == IW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = GRANT_IDX + 1'b1;
      end
    end
  end

  // pointer register
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Shares register-bank write access among NUM_REQ masters.
// One round-robin grant per cycle, write lands one cycle later.
module reg_bank_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   STALL,
  reg_bank_write_arbiter_if.slave req,
  output logic [NUM_REGS-1:0]    REG_CE,
  output logic [DATA_WIDTH-1:0]  REG_DIN,
  output logic [IW-1:0]          GRANT_ID,
  output logic                   ADDR_ERR
);

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         gidx;
  logic                  hs;
  logic                  arb_en;
  reg_wr_t               sel;
  logic [ADDR_SPAN-1:0]  dec;
  logic                  oob;

  logic [NUM_REGS-1:0]   ce_q,   ce_d;
  logic [DATA_WIDTH-1:0] din_q,  din_d;
  logic [IW-1:0]         gid_q,  gid_d;
  logic                  aerr_q, aerr_d;

  assign arb_en        = RSTN & ~STALL;
  assign req.REQ_READY = grant;
  assign hs            = |(req.REQ_VALID & grant);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .ENABLE    (arb_en),
    .UPDATE    (hs),
    .VALID     (req.REQ_VALID),
    .GRANT     (grant),
    .GRANT_IDX (gidx)
  );

  // route the winner's request and decode its index
  always_comb begin
    sel      = '0;
    sel.addr = req.REQ_ADDR[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel.data = req.REQ_DATA[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    dec      = onehot_decode(sel.addr);
  end

  // decoded bits above the bank mean an out-of-range index
  if (NUM_REGS < ADDR_SPAN) begin : g_oob
    assign oob = |dec[ADDR_SPAN-1:NUM_REGS];
  end else begin : g_full
    assign oob = 1'b0;
  end

  // next write-stage contents; CE/ERR are single-cycle pulses
  always_comb begin
    ce_d   = '0;
    din_d  = din_q;
    gid_d  = gid_q;
    aerr_d = 1'b0;
    if (hs) begin
      din_d = sel.data;
      gid_d = gidx;
      if (oob) begin
        aerr_d = 1'b1;
      end else begin
        ce_d = dec[NUM_REGS-1:0];
      end
    end
  end

  // write-stage register
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ce_q   <= '0;
      din_q  <= '0;
      gid_q  <= '0;
      aerr_q <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      din_q  <= din_d;
      gid_q  <= gid_d;
      aerr_q <= aerr_d;
    end
  end

  assign REG_CE   = ce_q;
  assign REG_DIN  = din_q;
  assign GRANT_ID = gid_q;
  assign ADDR_ERR = aerr_q;

endmodule
